serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
Parallel-to-serial frame transmitter that drives the single-bit Din input of the sequence-detector FSM, one bit per Clock cycle. It accepts a WIDTH-bit word over a Load/Ready handshake and shifts it out on Dout. After each frame it inserts GAP_CYCLES forced-zero cycles, so the downstream detector returns to its start state between frames.

Parameters:
WIDTH, 8, bits per frame (minimum 2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
GAP_CYCLES, 2, forced-zero cycles inserted after each frame (0 allowed)

Ports:
Clock  input  1  system clock; all state changes on posedge
Reset  input  1  synchronous, active-high reset
Load  input  1  request to transmit DataIn; qualified by Ready
DataIn  input  WIDTH  word to serialize; sampled only on an accepting edge
Ready  output  1  block can accept a word this cycle
Dout  output  1  serial bit stream to downstream detector Din; registered
Busy  output  1  high in SHIFT and GAP states
FrameDone  output  1  one-cycle pulse, coincident with the last data bit on Dout

Behaviour:
- Interface: one clock (Clock). Reset is synchronous and active-high.
- States: IDLE, SHIFT, GAP. Use a 2-bit state register. The unused code returns to IDLE.
- Reset (sampled high at a posedge):
  - Next state is IDLE, shift register is 0, counters are 0.
  - Dout=0, Busy=0, FrameDone=0.
  - Ready is forced 0 while Reset is high.
- Accept: Load && Ready sampled at posedge k.
  - DataIn is captured into the shift register at that edge.
  - The first data bit appears on Dout in cycle k+1 (one-cycle latency).
- Load while Ready=0 is ignored. DataIn is not captured and no error is flagged.
- IDLE:
  - Ready=1, Dout=0, Busy=0.
  - On accept, go to SHIFT.
- SHIFT:
  - Outputs WIDTH bits on consecutive cycles k+1..k+WIDTH, in the order set by MSB_FIRST.
  - Bit counter runs 0..WIDTH-1, width $clog2(WIDTH).
  - FrameDone=1 only during the cycle carrying the last bit.
  - After the last bit: go to GAP if GAP_CYCLES>0, otherwise IDLE.
- Back-to-back (GAP_CYCLES=0 only):
  - Ready is also 1 during the last-bit cycle of SHIFT.
  - An accept there reloads the shift register and stays in SHIFT.
  - The next frame's first bit follows with no idle cycle.
- GAP:
  - Dout=0, Ready=0, Busy=1 for exactly GAP_CYCLES cycles (counter width $clog2(GAP_CYCLES+1)).
  - Then go to IDLE.
- Dout is a flop output in every state. It is 0 in IDLE and GAP, never X after reset.
- Reset mid-frame or mid-gap: the frame is discarded. Next cycle is IDLE with Dout=0, and no FrameDone pulse.
- Load held continuously high: a new frame starts each time Ready returns. Frame period is WIDTH+GAP_CYCLES+1 cycles, or WIDTH when GAP_CYCLES=0.
- Simultaneous Reset and Load: Reset wins and nothing is captured.

Decomposition:
- Shared package:
  - state encoding localparams (ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_GAP=2'b10);
  - default WIDTH and GAP_CYCLES constants, reused by the detector test harness.
- No sub-module is required. The bit and gap counters stay inline in the single module.

Test Plan:
- Reset: hold Reset=1 for 3 cycles with Load=1 and DataIn=8'hFF -> Dout=0, Busy=0, FrameDone=0, Ready=0 throughout. After release, Ready=1 and Dout stays 0.
- Basic frame: WIDTH=8, MSB_FIRST=1, GAP=2, accept 8'hA5 at edge k.
  - Dout=1,0,1,0,0,1,0,1 on cycles k+1..k+8.
  - FrameDone=1 only at k+8.
  - Dout=0 and Ready=0 at k+9 and k+10.
  - Ready=1 at k+11.
- LSB-first: MSB_FIRST=0, accept 8'h01 -> Dout=1 at k+1, then 0 for k+2..k+8.
- Ignored load: pulse Load with DataIn=8'h00 at k+3 during the 8'hA5 frame -> the stream is unchanged, and no second frame follows.
- Back-to-back: GAP=0, Load held high, words 8'hF0 then 8'h0F -> 16 contiguous bits 1111000000001111, FrameDone at k+8 and k+16, no idle cycle between.
- Reset mid-frame: assert Reset at k+4 of 8'hFF -> Dout=0 from the next cycle, no FrameDone. The next accepted frame transmits correctly.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared constants for the serial frame transmitter and the
// detector harness that reuses its default frame geometry.
package serial_frame_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_MSB_FIRST  = 1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Load/Ready word handshake plus the serial output bundle
// of the frame transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);

    logic             Load;
    logic [WIDTH-1:0] DataIn;
    logic             Ready;
    logic             Dout;
    logic             Busy;
    logic             FrameDone;

    modport master (
        output Load,
        output DataIn,
        input  Ready,
        input  Dout,
        input  Busy,
        input  FrameDone
    );

    modport slave (
        input  Load,
        input  DataIn,
        output Ready,
        output Dout,
        output Busy,
        output FrameDone
    );

endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: one word per frame,
// followed by forced-zero gap cycles to resync the detector.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MSB_FIRST  = DEF_MSB_FIRST,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic         Clock,
    input  logic         Reset,
    serial_frame_tx_if.slave bus
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);
    localparam logic [GW-1:0] LAST_GAP =
        (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             dout_q;
    logic             done_q;

    logic in_shift;
    logic in_gap;
    logic last_bit;
    logic gap_end;
    logic ready;
    logic accept;

    // Bit that leaves first from a word, in the configured order.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed.
    function automatic logic [WIDTH-1:0] advance(
        input logic [WIDTH-1:0] w
    );
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0}
                                : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_shift = (state == ST_SHIFT);
    assign in_gap   = (state == ST_GAP);
    assign last_bit = in_shift && (bit_cnt == LAST_BIT);
    assign gap_end  = in_gap && (gap_cnt == LAST_GAP);

    // With no gap, the last-bit cycle can already take the next word.
    assign ready = !Reset &&
                   ((state == ST_IDLE) ||
                    ((GAP_CYCLES == 0) && last_bit));

    assign accept = bus.Load && ready;

    assign bus.Ready     = ready;
    assign bus.Dout      = dout_q;
    assign bus.FrameDone = done_q;
    assign bus.Busy      = in_shift || in_gap;

    // Next-state selection; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                state_nxt = accept ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    state_nxt = ST_SHIFT;
                end else if (accept) begin
                    state_nxt = ST_SHIFT;
                end else if (GAP_CYCLES > 0) begin
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_nxt = gap_end ? ST_IDLE : ST_GAP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter: index of the bit currently on Dout.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bit_cnt <= '0;
        end else if (accept || last_bit) begin
            bit_cnt <= '0;
        end else if (in_shift) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Gap counter: cycles of forced zero already spent.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            gap_cnt <= '0;
        end else if (in_gap && !gap_end) begin
            gap_cnt <= gap_cnt + GW'(1);
        end else begin
            gap_cnt <= '0;
        end
    end

    // Shift register holds the bits not yet driven onto Dout.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= advance(bus.DataIn);
        end else if (in_shift && !last_bit) begin
            shreg <= advance(shreg);
        end
    end

    // Registered serial bit and last-bit marker.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            dout_q <= 1'b0;
            done_q <= 1'b0;
        end else if (accept) begin
            dout_q <= head(bus.DataIn);
            done_q <= 1'b0;
        end else if (in_shift && !last_bit) begin
            dout_q <= head(shreg);
            done_q <= (bit_cnt == PRE_LAST);
        end else begin
            dout_q <= 1'b0;
            done_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: two transmitter configurations driven with
// directed and random traffic against a timeline reference model.
module tb_serial_frame_tx;

    localparam int W = 8;
    localparam int MSB_A = 1;
    localparam int GAP_A = 2;
    localparam int MSB_B = 0;
    localparam int GAP_B = 0;

    typedef struct {
        int cyc;
        bit b;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    serial_frame_tx_if #(.WIDTH(W)) ifa ();
    serial_frame_tx_if #(.WIDTH(W)) ifb ();

    serial_frame_tx #(
        .WIDTH(W), .MSB_FIRST(MSB_A), .GAP_CYCLES(GAP_A)
    ) dut_a (
        .Clock(clk), .Reset(rst_a), .bus(ifa)
    );

    serial_frame_tx #(
        .WIDTH(W), .MSB_FIRST(MSB_B), .GAP_CYCLES(GAP_B)
    ) dut_b (
        .Clock(clk), .Reset(rst_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    exp_t qa[$];
    exp_t qb[$];
    int   nready [2];
    bit   exp_rdy[2];
    int   checks = 0;
    int   errors = 0;

    // Apply inputs for the current cycle and predict their effect.
    task automatic drive(input int d, input bit r, input bit l,
                         input logic [W-1:0] data);
        int c;
        int g;
        int m;
        exp_t e;
        c = edge_n + 1;
        g = (d == 0) ? GAP_A : GAP_B;
        m = (d == 0) ? MSB_A : MSB_B;
        if (d == 0) begin
            rst_a = r; ifa.Load = l; ifa.DataIn = data;
        end else begin
            rst_b = r; ifb.Load = l; ifb.DataIn = data;
        end
        exp_rdy[d] = !r && (c >= nready[d]);
        if (r) begin
            nready[d] = c + 1;
            if (d == 0) begin
                for (int i = qa.size() - 1; i >= 0; i--)
                    if (qa[i].cyc > c) qa.delete(i);
            end else begin
                for (int i = qb.size() - 1; i >= 0; i--)
                    if (qb[i].cyc > c) qb.delete(i);
            end
        end else if (l && exp_rdy[d]) begin
            for (int i = 0; i < W + g; i++) begin
                e.cyc  = c + 1 + i;
                e.b    = (i >= W) ? 1'b0 :
                         (m != 0) ? data[W-1-i] : data[i];
                e.last = (i == W - 1);
                if (d == 0) qa.push_back(e);
                else        qb.push_back(e);
            end
            nready[d] = (g > 0) ? c + W + g + 1 : c + W;
        end
    endtask

    task automatic cmp(input string name, input int d,
                       input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b",
                     name, d, edge_n + 1, act, req);
        end
    endtask

    // Compare one DUT's outputs against the head of its queue.
    task automatic check_one(input int d);
        int c;
        bit hit;
        exp_t e;
        c = edge_n + 1;
        hit = 1'b0;
        e.cyc = 0; e.b = 1'b0; e.last = 1'b0;
        if (d == 0) begin
            while (qa.size() > 0 && qa[0].cyc < c) void'(qa.pop_front());
            if (qa.size() > 0 && qa[0].cyc == c) begin
                e = qa.pop_front(); hit = 1'b1;
            end
            cmp("dout",  d, ifa.Dout,      e.b);
            cmp("done",  d, ifa.FrameDone, e.last);
            cmp("busy",  d, ifa.Busy,      hit);
            cmp("ready", d, ifa.Ready,     exp_rdy[d]);
        end else begin
            while (qb.size() > 0 && qb[0].cyc < c) void'(qb.pop_front());
            if (qb.size() > 0 && qb[0].cyc == c) begin
                e = qb.pop_front(); hit = 1'b1;
            end
            cmp("dout",  d, ifb.Dout,      e.b);
            cmp("done",  d, ifb.FrameDone, e.last);
            cmp("busy",  d, ifb.Busy,      hit);
            cmp("ready", d, ifb.Ready,     exp_rdy[d]);
        end
    endtask

    always @(negedge clk) begin
        if (edge_n >= 1) begin
            check_one(0);
            check_one(1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive(d, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic random_run(input int d, input int n);
        bit r;
        bit l;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 9) < 6);
            drive(d, r, l, 8'($urandom));
        end
    endtask

    task automatic seq_a();
        drive(0, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); drive(0, 1'b1, 1'b1, 8'hFF);
        end
        idle(0, 2);
        next_cycle(); drive(0, 1'b0, 1'b1, 8'hA5);
        idle(0, 2);
        next_cycle(); drive(0, 1'b0, 1'b1, 8'h00);
        idle(0, 12);
        next_cycle(); drive(0, 1'b0, 1'b1, 8'hFF);
        idle(0, 3);
        next_cycle(); drive(0, 1'b1, 1'b0, 8'h00);
        idle(0, 2);
        next_cycle(); drive(0, 1'b0, 1'b1, 8'h3C);
        idle(0, 14);
        random_run(0, 1500);
        idle(0, 16);
    endtask

    task automatic seq_b();
        drive(1, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); drive(1, 1'b1, 1'b1, 8'hFF);
        end
        idle(1, 2);
        next_cycle(); drive(1, 1'b0, 1'b1, 8'h01);
        idle(1, 10);
        next_cycle(); drive(1, 1'b0, 1'b1, 8'hF0);
        for (int i = 0; i < 8; i++) begin
            next_cycle(); drive(1, 1'b0, 1'b1, 8'h0F);
        end
        idle(1, 12);
        random_run(1, 1500);
        idle(1, 16);
    endtask

    initial begin
        ifa.Load = 1'b0; ifa.DataIn = '0;
        ifb.Load = 1'b0; ifb.DataIn = '0;
        nready[0] = 0; nready[1] = 0;
        exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: left %0d/%0d expected 0/0",
                     qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t limit 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
